// File: rtl/apb3_master_pkg.sv
// Shared APB3 master definitions: FSM states, default bus widths and the
// peripheral address map, for requesters and benches.
package apb3_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;

  localparam logic [7:0] ADDR_NEOPIXEL  = 8'h00;
  localparam logic [7:0] ADDR_SERVO     = 8'h04;
  localparam logic [7:0] ADDR_RSA_FIRST = 8'h08;
  localparam logic [7:0] ADDR_RSA_LAST  = 8'h24;

endpackage

// File: rtl/apb3_master_wait_timer.sv
// ACCESS-phase wait counter: cleared in SETUP, counts PREADY-low cycles,
// flags the last permitted wait cycle.
module apb3_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb3_master.sv
// APB3 initiator: one blocking command/response per transfer, with a
// bounded PREADY wait that aborts with an error on timeout.
module apb3_master
  import apb3_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_t state, state_nxt;
  logic       accept;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_tc;

  apb3_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk (PCLK),
    .rst (PRESET),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  assign accept  = (state == IDLE) && req_valid;
  assign tmr_clr = (state == SETUP);
  assign tmr_en  = (state == ACCESS) && !PREADY && !tmr_tc;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || tmr_tc) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs decode the state register only, so no input reaches them combinationally.
  always_comb begin
    req_ready  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:    req_ready = 1'b1;
      SETUP:   PSEL = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= req_write;
      PADDR  <= req_addr;
      PWDATA <= req_wdata;
    end
  end

  // PREADY wins over the terminal count when both land on the same cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else if (state == ACCESS) begin
      if (PREADY) begin
        resp_rdata   <= PWRITE ? '0 : PRDATA;
        resp_err     <= PSLVERR;
        resp_timeout <= 1'b0;
      end else if (tmr_tc) begin
        resp_rdata   <= '0;
        resp_err     <= 1'b1;
        resp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb3_master.sv
// Directed bench for apb3_master with TIMEOUT = 4; expectations are
// hand-derived cycle by cycle from the acceptance edge.
module tb_apb3_master;

  logic        PCLK;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic        busy;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int errors = 0;
  int checks = 0;

  apb3_master #(
    .ADDR_W (8),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .resp_timeout(resp_timeout),
    .busy        (busy),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic start_req(input logic w, input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    #1;
    checks++; if (PSEL !== 1'b0) begin errors++; $display("FAIL rst_psel: got %b want 0", PSEL); end
    checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({PWRITE, PADDR, PWDATA} !== 41'd0) begin errors++; $display("FAIL rst_bus_regs: got %h want 0", {PWRITE, PADDR, PWDATA}); end
    checks++; if ({resp_err, resp_timeout, resp_rdata} !== 34'd0) begin errors++; $display("FAIL rst_resp_regs: got %h want 0", {resp_err, resp_timeout, resp_rdata}); end
    tick();
    tick();
    PRESET = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_zero_wait_write();
    start_req(1'b1, 8'h04, 32'h0000_05DC);
    tick();
    req_valid = 1'b0;
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin errors++; $display("FAIL zw_setup: got %b want 10", {PSEL, PENABLE}); end
    checks++; if ({PWRITE, PADDR} !== 9'h104) begin errors++; $display("FAIL zw_addr: got %h want 104", {PWRITE, PADDR}); end
    checks++; if (PWDATA !== 32'h0000_05DC) begin errors++; $display("FAIL zw_pwdata_c1: got %h want 000005dc", PWDATA); end
    checks++; if ({req_ready, busy} !== 2'b01) begin errors++; $display("FAIL zw_ready_busy: got %b want 01", {req_ready, busy}); end
    tick();
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL zw_access: got %b want 11", {PSEL, PENABLE}); end
    checks++; if (PWDATA !== 32'h0000_05DC) begin errors++; $display("FAIL zw_pwdata_c2: got %h want 000005dc", PWDATA); end
    tick();
    checks++; if ({resp_valid, PSEL} !== 2'b10) begin errors++; $display("FAIL zw_resp: got %b want 10", {resp_valid, PSEL}); end
    checks++; if ({resp_err, resp_timeout, resp_rdata} !== 34'd0) begin errors++; $display("FAIL zw_resp_fields: got %h want 0", {resp_err, resp_timeout, resp_rdata}); end
    tick();
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL zw_next_accept: got %b want 10", {req_ready, resp_valid}); end
  endtask

  task automatic test_read_waits();
    start_req(1'b0, 8'h10, 32'hFFFF_FFFF);
    PREADY = 1'b0;
    PRDATA = 32'h1111_1111;
    tick();
    req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) begin
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
      end
      checks++; if ({PSEL, PENABLE, resp_valid} !== 3'b110) begin errors++; $display("FAIL rd_wait_c%0d: got %b want 110", c, {PSEL, PENABLE, resp_valid}); end
    end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", resp_rdata); end
    checks++; if ({resp_err, resp_timeout} !== 2'b00) begin errors++; $display("FAIL rd_err: got %b want 00", {resp_err, resp_timeout}); end
    tick();
  endtask

  task automatic test_slave_error();
    start_req(1'b1, 8'h08, 32'h0000_0001);
    tick();
    req_valid = 1'b0;
    PSLVERR   = 1'b1;
    tick();
    tick();
    PSLVERR = 1'b0;
    checks++; if ({resp_valid, resp_err, resp_timeout} !== 3'b110) begin errors++; $display("FAIL slverr_set: got %b want 110", {resp_valid, resp_err, resp_timeout}); end
    tick();
    start_req(1'b1, 8'h0C, 32'h0000_0002);
    tick();
    req_valid = 1'b0;
    PSLVERR   = 1'b1;
    tick();
    PSLVERR = 1'b0;
    tick();
    checks++; if ({resp_valid, resp_err, resp_timeout} !== 3'b100) begin errors++; $display("FAIL slverr_setup_ignored: got %b want 100", {resp_valid, resp_err, resp_timeout}); end
    tick();
  endtask

  task automatic test_timeout();
    int accesses = 0;
    int resp_cycle = 0;
    start_req(1'b0, 8'h14, 32'h0);
    PREADY = 1'b0;
    PRDATA = 32'hCAFE_F00D;
    tick();
    req_valid = 1'b0;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (resp_valid === 1'b1) begin
        resp_cycle = c;
        break;
      end
      if (PSEL === 1'b1 && PENABLE === 1'b1) accesses++;
    end
    checks++; if (accesses !== 4) begin errors++; $display("FAIL to_access_cycles: got %0d want 4", accesses); end
    checks++; if (resp_cycle !== 6) begin errors++; $display("FAIL to_resp_cycle: got %0d want 6", resp_cycle); end
    checks++; if ({resp_err, resp_timeout, PSEL} !== 3'b110) begin errors++; $display("FAIL to_flags: got %b want 110", {resp_err, resp_timeout, PSEL}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", resp_rdata); end
    PREADY = 1'b1;
    tick();
  endtask

  task automatic test_ready_at_limit();
    start_req(1'b1, 8'h20, 32'h0000_00A5);
    PREADY = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) PREADY = 1'b1;
    end
    tick();
    checks++; if ({resp_valid, resp_err, resp_timeout} !== 3'b100) begin errors++; $display("FAIL limit_complete: got %b want 100", {resp_valid, resp_err, resp_timeout}); end
    tick();
  endtask

  task automatic test_back_pressure();
    start_req(1'b0, 8'h24, 32'h0);
    PRDATA     = 32'h1234_5678;
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL bp_first: got %h want 112345678", {resp_valid, resp_rdata}); end
    for (int s = 0; s < 5; s++) begin
      PRDATA = 32'h0BAD_0000 + 32'(s);
      tick();
      checks++; if ({resp_valid, req_ready, PSEL, busy, resp_rdata} !== {4'b1001, 32'h1234_5678}) begin errors++; $display("FAIL bp_stall%0d: got %h want 912345678", s, {resp_valid, req_ready, PSEL, busy, resp_rdata}); end
    end
    resp_ready = 1'b1;
    tick();
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got %b want 10", {req_ready, resp_valid}); end
  endtask

  task automatic test_reset_mid_transfer();
    start_req(1'b1, 8'h08, 32'h0000_0077);
    PREADY = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL mr_in_access: got %b want 11", {PSEL, PENABLE}); end
    #2;
    PRESET = 1'b1;
    #1;
    checks++; if ({PSEL, PENABLE, resp_valid, busy} !== 4'b0000) begin errors++; $display("FAIL mr_async_drop: got %b want 0000", {PSEL, PENABLE, resp_valid, busy}); end
    checks++; if (PADDR !== 8'h00) begin errors++; $display("FAIL mr_paddr: got %h want 00", PADDR); end
    tick();
    PRESET = 1'b0;
    PREADY = 1'b1;
    tick();
    checks++; if ({req_ready, resp_valid, PSEL} !== 3'b100) begin errors++; $display("FAIL mr_after_release: got %b want 100", {req_ready, resp_valid, PSEL}); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mr_no_resp: got %b want 0", resp_valid); end
  endtask

  initial begin
    PRESET     = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    PRDATA     = 32'h0;
    PREADY     = 1'b1;
    PSLVERR    = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_read_waits();
    test_slave_error();
    test_timeout();
    test_ready_at_limit();
    test_back_pressure();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
